// File: rtl/parity_gen_chk.sv
// TX parity generator and RX parity checker for the UART/serial path.
// Optional macro PARITY_ERR_CNT_EN builds the saturating RX error counter; otherwise err_cnt is tied to 0.
module parity_gen_chk #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     par_en,
  input  logic [1:0]               par_mode,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     data_valid,
  input  logic                     busy,
  output logic                     parity_bit,
  output logic                     parity_valid,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_par_bit,
  input  logic                     rx_strobe,
  output logic                     par_err,
  output logic                     par_err_sticky,
  input  logic                     clr_err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } tx_state_e;

  function automatic logic par_fn(input logic [DATA_WIDTH-1:0] d, input logic [1:0] m);
    logic r;
    case (par_mode_e'(m))
      PAR_EVEN:  r = ^d;
      PAR_ODD:   r = ~^d;
      PAR_MARK:  r = 1'b1;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  // ---------------- TX side ----------------
  tx_state_e             state, state_nxt;
  logic [DATA_WIDTH-1:0] data_reg, data_nxt;
  logic [1:0]            mode_reg, mode_nxt;
  logic                  en_reg, en_nxt;
  logic                  parity_nxt, valid_nxt;
  logic                  capture;

  assign capture = data_valid && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      data_reg     <= '0;
      mode_reg     <= '0;
      en_reg       <= 1'b0;
      parity_bit   <= 1'b0;
      parity_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      data_reg     <= data_nxt;
      mode_reg     <= mode_nxt;
      en_reg       <= en_nxt;
      parity_bit   <= parity_nxt;
      parity_valid <= valid_nxt;
    end
  end

  // In HOLD the parity is regenerated from the captured word/mode/enable,
  // which equals the held value; live par_mode/par_en changes are ignored.
  always_comb begin
    state_nxt  = state;
    data_nxt   = data_reg;
    mode_nxt   = mode_reg;
    en_nxt     = en_reg;
    parity_nxt = parity_bit;
    valid_nxt  = parity_valid;
    if (capture) begin
      state_nxt  = HOLD;
      data_nxt   = data_in;
      mode_nxt   = par_mode;
      en_nxt     = par_en;
      parity_nxt = par_en ? par_fn(data_in, par_mode) : 1'b0;
      valid_nxt  = 1'b1;
    end else begin
      case (state)
        HOLD: begin
          parity_nxt = en_reg ? par_fn(data_reg, mode_reg) : 1'b0;
          valid_nxt  = 1'b1;
        end
        default: begin
          valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // ---------------- RX side ----------------
  logic rx_mismatch;

  assign rx_mismatch = rx_strobe && par_en && (par_fn(rx_data, par_mode) != rx_par_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err        <= 1'b0;
      par_err_sticky <= 1'b0;
    end else begin
      par_err <= rx_mismatch;
      if (clr_err)
        par_err_sticky <= 1'b0;
      else if (rx_mismatch)
        par_err_sticky <= 1'b1;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (clr_err)
      err_cnt <= '0;
    else if (rx_mismatch && (err_cnt != '1))
      err_cnt <= err_cnt + 1'b1;
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_parity_gen_chk.sv
// Self-checking bench for parity_gen_chk: directed literal checks plus a per-cycle behavioural model.
module tb_parity_gen_chk;
  localparam int DW  = 8;
  localparam int CW  = 8;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef PARITY_ERR_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          par_en = 1'b0;
  logic [1:0]    par_mode = 2'b00;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          busy = 1'b0;
  logic          parity_bit, parity_valid;
  logic [DW-1:0] rx_data = '0;
  logic          rx_par_bit = 1'b0;
  logic          rx_strobe = 1'b0;
  logic          par_err, par_err_sticky;
  logic          clr_err = 1'b0;
  logic [CW-1:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;

  parity_gen_chk #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .par_en(par_en), .par_mode(par_mode),
    .data_in(data_in), .data_valid(data_valid), .busy(busy),
    .parity_bit(parity_bit), .parity_valid(parity_valid),
    .rx_data(rx_data), .rx_par_bit(rx_par_bit), .rx_strobe(rx_strobe),
    .par_err(par_err), .par_err_sticky(par_err_sticky),
    .clr_err(clr_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Parity expected for a word under a mode, from a ones count.
  function automatic bit p_ref(input logic [DW-1:0] d, input logic [1:0] m);
    int ones;
    ones = $countones(d);
    case (m)
      2'd0:    return (ones % 2) == 1;
      2'd1:    return (ones % 2) == 0;
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Behavioural reference.
  bit m_pb, m_pv, m_err, m_sticky;
  int m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pb = 0; m_pv = 0; m_err = 0; m_sticky = 0; m_cnt = 0;
    end else begin
      if (data_valid && !busy) begin
        m_pb = par_en ? p_ref(data_in, par_mode) : 1'b0;
        m_pv = 1;
      end
      m_err = rx_strobe && par_en && (p_ref(rx_data, par_mode) != rx_par_bit);
      if (clr_err) begin
        m_sticky = 0;
        m_cnt    = 0;
      end else if (m_err) begin
        m_sticky = 1;
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_parity_bit", parity_bit, m_pb);
      chk("m_parity_valid", parity_valid, m_pv);
      chk("m_par_err", par_err, m_err);
      chk("m_sticky", par_err_sticky, m_sticky);
      chk("m_err_cnt", err_cnt, CNT_ON * m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset values
    step(); step();
    chk("rst_pb", parity_bit, 0);
    chk("rst_pv", parity_valid, 0);
    chk("rst_err", par_err, 0);
    chk("rst_sticky", par_err_sticky, 0);
    chk("rst_cnt", err_cnt, 0);
    rst_n = 1'b1;
    step();
    chk("idle_pv", parity_valid, 0);

    // TX even parity
    par_en = 1; par_mode = 2'b00; data_in = 8'hA5; data_valid = 1;
    step();
    chk("even_A5_pb", parity_bit, 0);
    chk("even_A5_pv", parity_valid, 1);
    data_in = 8'h07;
    step();
    chk("even_07_pb", parity_bit, 1);
    data_valid = 0;

    // odd / mark / space / hold
    par_mode = 2'b01; data_in = 8'hA5; data_valid = 1;
    step();
    chk("odd_A5_pb", parity_bit, 1);
    data_valid = 0; par_mode = 2'b10; data_in = 8'h00;
    step(); step();
    chk("hold_pb", parity_bit, 1);
    chk("hold_pv", parity_valid, 1);
    par_mode = 2'b11; data_valid = 1;
    step();
    chk("space_pb", parity_bit, 0);
    par_mode = 2'b10;
    step();
    chk("mark_pb", parity_bit, 1);
    par_mode = 2'b11;
    step();
    chk("space2_pb", parity_bit, 0);
    data_valid = 0;

    // busy blocks capture
    par_mode = 2'b01; data_in = 8'hFF; busy = 1; data_valid = 1;
    step(); step();
    chk("busy_pb", parity_bit, 0);
    chk("busy_pv", parity_valid, 1);
    busy = 0;
    step();
    chk("release_pb", parity_bit, 1);
    for (int i = 0; i < 4; i++) begin
      data_in = (i % 2 == 0) ? 8'h01 : 8'h03;
      step();
      chk("b2b_pv", parity_valid, 1);
      chk("b2b_pb", parity_bit, (i % 2 == 0) ? 0 : 1);
    end
    data_valid = 0;

    // RX error, saturation, matching frame
    clr_err = 1;
    step();
    clr_err = 0; par_mode = 2'b00; rx_data = 8'h01; rx_par_bit = 0; rx_strobe = 1;
    step();
    chk("rx_err", par_err, 1);
    chk("rx_sticky", par_err_sticky, 1);
    chk("rx_cnt1", err_cnt, CNT_ON * 1);
    rx_strobe = 0;
    step();
    chk("rx_err_pulse", par_err, 0);
    chk("rx_sticky_hold", par_err_sticky, 1);
    rx_strobe = 1;
    for (int i = 0; i < 300; i++) step();
    chk("rx_sat", err_cnt, CNT_ON * 255);
    rx_par_bit = 1;
    step();
    chk("rx_match", par_err, 0);
    chk("rx_sat_hold", err_cnt, CNT_ON * 255);

    // clear collision
    rx_par_bit = 0; clr_err = 1;
    step();
    chk("clr_err_pulse", par_err, 1);
    chk("clr_sticky", par_err_sticky, 0);
    chk("clr_cnt", err_cnt, 0);
    clr_err = 0;

    // parity disabled
    par_en = 0; par_mode = 2'b10; data_in = 8'h5A; data_valid = 1;
    step();
    chk("dis_err", par_err, 0);
    chk("dis_sticky", par_err_sticky, 0);
    chk("dis_pb", parity_bit, 0);
    data_valid = 0; rx_strobe = 0; par_en = 1;

    // reset mid-HOLD with a count of 5
    par_mode = 2'b00; rx_strobe = 1;
    for (int i = 0; i < 5; i++) step();
    rx_strobe = 0; par_mode = 2'b10; data_valid = 1;
    step();
    data_valid = 0;
    chk("pre_rst_cnt", err_cnt, CNT_ON * 5);
    chk("pre_rst_pb", parity_bit, 1);
    rst_n = 0;
    #1;
    chk("arst_pb", parity_bit, 0);
    chk("arst_pv", parity_valid, 0);
    chk("arst_err", par_err, 0);
    chk("arst_sticky", par_err_sticky, 0);
    chk("arst_cnt", err_cnt, 0);
    step();
    rst_n = 1;
    step(); step();
    chk("post_rst_idle_pv", parity_valid, 0);

    // randomized traffic, compared every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      par_en     = ($urandom_range(0, 7) != 0);
      par_mode   = 2'($urandom_range(0, 3));
      data_in    = 8'($urandom);
      data_valid = $urandom_range(0, 1) == 1;
      busy       = $urandom_range(0, 3) == 0;
      rx_data    = 8'($urandom);
      rx_par_bit = $urandom_range(0, 1) == 1;
      rx_strobe  = $urandom_range(0, 1) == 1;
      clr_err    = $urandom_range(0, 63) == 0;
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 0;
        #2;
        rst_n = 1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
